div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle sequencer that runs MIPS DIV/DIVU (32-bit signed/unsigned divide) on the shared combinational 64-bit adder/subtractor, one adder operation per cycle.
- Owns the adder operand/mode inputs while busy; sits between EX-stage issue logic and the adder, and writes HI/LO results back to EX.
- Fixed latency for non-zero divisors so the pipeline stall counter is static.

Parameters:
- ZERO_QUOT, 32'hFFFF_FFFF, quotient returned when divisor is 0.
- ITER_N, 32, restoring iterations; must equal the 32-bit operand width and is not changed.

Ports:
- CLK  in  1  clock, rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- START  in  1  request; sampled only in IDLE.
- SIGNED  in  1  1=DIV, 0=DIVU; latched at START.
- DIVIDEND  in  32  latched at START.
- DIVISOR  in  32  latched at START.
- CANCEL  in  1  flush (exception/branch); aborts the operation.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse; results are valid from this cycle.
- QUOTIENT  out  32  to LO; held until the next accepted START.
- REMAINDER  out  32  to HI; held until the next accepted START.
- DIV_ZERO  out  1  divisor was 0; held with the results.
- ADD_A  out  64  adder operand 1.
- ADD_B  out  64  adder operand 2; the adder inverts it itself when subtracting.
- ADD_SUB  out  1  adder subtract select.
- ADD_CIN  out  1  adder carry-in; always 0, because the adder combines it with the subtract select internally.
- ADD_SUM  in  64  adder result, combinational from ADD_A/ADD_B/ADD_SUB in the same cycle.

Behaviour:
- Reset: state=IDLE; all registers 0; BUSY=0, DONE=0, QUOTIENT=0, REMAINDER=0, DIV_ZERO=0; ADD_A=0, ADD_B=0, ADD_SUB=0.
- States: IDLE, NEG_A, NEG_B, ITER, FIX_Q, FIX_R, FINISH.
- Adder drive outside NEG_*/ITER/FIX_*: ADD_A=0, ADD_B=0, ADD_SUB=0.
- Negate helper, neg(x): ADD_A=0, ADD_B={32'b0,x}, ADD_SUB=1; result is ADD_SUM[31:0].
- IDLE:
  - START=1 and CANCEL=0: latch operands and SIGNED; clear DONE/DIV_ZERO.
  - Divisor==0: go to FINISH with QUOTIENT=ZERO_QUOT, REMAINDER=DIVIDEND, DIV_ZERO=1.
  - Otherwise go to NEG_A.
- NEG_A: if SIGNED and dividend[31], a_abs=neg(dividend); else a_abs=dividend (adder idle). Go to NEG_B. Uses one cycle either way.
- NEG_B: same for the divisor into b_abs. Clear rem33 and cnt. Go to ITER.
- ITER, one step per cycle, cnt 0..31:
  - Shift: p={rem33[31:0], a_abs[31]}.
  - Drive ADD_A={31'b0,p}, ADD_B={32'b0,b_abs}, ADD_SUB=1.
  - If ADD_SUM[63]==0: rem33 = ADD_SUM[32:0], quotient bit = 1. Else: rem33 = p, quotient bit = 0.
  - a_abs shifts left, with the quotient bit entering at bit 0.
  - Go to FIX_Q after cnt==31.
- FIX_Q: if SIGNED and dividend[31]^divisor[31], QUOTIENT=neg(q); else QUOTIENT=q.
- FIX_R: if SIGNED and dividend[31], REMAINDER=neg(r); else REMAINDER=r.
- FINISH: DONE=1 for this cycle; next state IDLE.
- Latency: START accepted at edge 0 -> DONE high in cycle 37 (1+1+32+1+1+1). Divide-by-zero -> DONE in cycle 1.
- A new START is accepted in the IDLE cycle right after FINISH, giving a back-to-back period of 38 cycles.
- START while BUSY: ignored, with no queuing.
- CANCEL (any non-IDLE state): next edge goes to IDLE, BUSY=0, no DONE. QUOTIENT/REMAINDER/DIV_ZERO keep their previous values.
- CANCEL together with START in IDLE: CANCEL wins and START is not accepted.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF gives Q=0x8000_0000, R=0, with no trap and no flag.
- Asynchronous reset asserted mid-operation: immediate return to reset values; no DONE.

Test Plan:
- DIVU 100/7 -> DONE in cycle 37, Q=14, R=2, DIV_ZERO=0. BUSY high cycles 1-37 and low in cycle 38.
- DIV -7/2 (0xFFFF_FFF9, 2) -> Q=0xFFFF_FFFD, R=0xFFFF_FFFF. DIV 7/-2 -> Q=0xFFFF_FFFD, R=1.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> Q=0x8000_0000, R=0. DIVU 0xFFFF_FFFF/1 -> Q=0xFFFF_FFFF, R=0.
- DIVU 5/0 -> DONE in cycle 1, Q=0xFFFF_FFFF, R=5, DIV_ZERO=1. The adder inputs stay 0 throughout.
- Start 100/7, pulse CANCEL in cycle 10 -> idle next cycle, no DONE, outputs keep prior values. A new START 9/3 then gives Q=3, R=0 in 37 cycles.
- START pulsed while BUSY -> ignored. Assert RESETN=0 in cycle 20 -> all outputs 0 immediately; a following START runs normally.

Source files
------------

// File: rtl/div_seq.sv
// Sequential restoring divider for MIPS DIV/DIVU. It borrows the shared 64-bit adder,
// using one add/subtract per cycle, and has a fixed 37-cycle latency for non-zero divisors.
module div_seq #(
  parameter logic [31:0] ZERO_QUOT = 32'hFFFF_FFFF,
  parameter int unsigned ITER_N    = 32
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        START,
  input  logic        SIGNED,
  input  logic [31:0] DIVIDEND,
  input  logic [31:0] DIVISOR,
  input  logic        CANCEL,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] QUOTIENT,
  output logic [31:0] REMAINDER,
  output logic        DIV_ZERO,
  output logic [63:0] ADD_A,
  output logic [63:0] ADD_B,
  output logic        ADD_SUB,
  output logic        ADD_CIN,
  input  logic [63:0] ADD_SUM
);

  localparam int unsigned CntW = $clog2(ITER_N);
  localparam logic [CntW-1:0] LastCnt = CntW'(ITER_N - 1);

  typedef enum logic [2:0] {
    StIdle, StNegA, StNegB, StIter, StFixQ, StFixR, StFinish
  } state_e;

  state_e          state_q;
  logic            signed_q;
  logic            sign_a_q;
  logic            sign_b_q;
  logic [31:0]     a_abs_q;   // dividend magnitude, then quotient bits shifted in
  logic [31:0]     b_abs_q;
  logic [31:0]     rem_q;     // partial remainder; always < divisor, so 32 bits suffice
  logic [CntW-1:0] cnt_q;
  logic [31:0]     quot_q;
  logic [31:0]     rem_out_q;
  logic            div_zero_q;
  logic            done_q;

  logic        neg_a;
  logic        neg_b;
  logic        neg_q;
  logic [32:0] p;
  logic        trial_ok;
  logic        unused_sum;

  assign neg_a    = signed_q & sign_a_q;
  assign neg_b    = signed_q & sign_b_q;
  assign neg_q    = signed_q & (sign_a_q ^ sign_b_q);
  assign p        = {rem_q, a_abs_q[31]};
  assign trial_ok = ~ADD_SUM[63];
  assign unused_sum = ^ADD_SUM[62:32];

  // Adder drive is decoded from the current state so ADD_SUM is usable in the same cycle.
  always_comb begin
    ADD_A   = '0;
    ADD_B   = '0;
    ADD_SUB = 1'b0;
    case (state_q)
      StNegA: begin
        if (neg_a) begin
          ADD_B   = {32'b0, a_abs_q};
          ADD_SUB = 1'b1;
        end
      end
      StNegB: begin
        if (neg_b) begin
          ADD_B   = {32'b0, b_abs_q};
          ADD_SUB = 1'b1;
        end
      end
      StIter: begin
        ADD_A   = {31'b0, p};
        ADD_B   = {32'b0, b_abs_q};
        ADD_SUB = 1'b1;
      end
      StFixQ: begin
        if (neg_q) begin
          ADD_B   = {32'b0, a_abs_q};
          ADD_SUB = 1'b1;
        end
      end
      StFixR: begin
        if (neg_a) begin
          ADD_B   = {32'b0, rem_q};
          ADD_SUB = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= StIdle;
      signed_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      a_abs_q    <= '0;
      b_abs_q    <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_out_q  <= '0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != StIdle && CANCEL) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (START && !CANCEL) begin
              signed_q   <= SIGNED;
              sign_a_q   <= DIVIDEND[31];
              sign_b_q   <= DIVISOR[31];
              a_abs_q    <= DIVIDEND;
              b_abs_q    <= DIVISOR;
              div_zero_q <= 1'b0;
              if (DIVISOR == '0) begin
                quot_q     <= ZERO_QUOT;
                rem_out_q  <= DIVIDEND;
                div_zero_q <= 1'b1;
                done_q     <= 1'b1;
                state_q    <= StFinish;
              end else begin
                state_q <= StNegA;
              end
            end
          end
          StNegA: begin
            if (neg_a) a_abs_q <= ADD_SUM[31:0];
            state_q <= StNegB;
          end
          StNegB: begin
            if (neg_b) b_abs_q <= ADD_SUM[31:0];
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= StIter;
          end
          StIter: begin
            rem_q   <= trial_ok ? ADD_SUM[31:0] : p[31:0];
            a_abs_q <= {a_abs_q[30:0], trial_ok};
            cnt_q   <= cnt_q + CntW'(1);
            if (cnt_q == LastCnt) state_q <= StFixQ;
          end
          StFixQ: begin
            quot_q  <= neg_q ? ADD_SUM[31:0] : a_abs_q;
            state_q <= StFixR;
          end
          StFixR: begin
            rem_out_q <= neg_a ? ADD_SUM[31:0] : rem_q;
            done_q    <= 1'b1;
            state_q   <= StFinish;
          end
          StFinish: state_q <= StIdle;
          default:  state_q <= StIdle;
        endcase
      end
    end
  end

  assign BUSY      = (state_q != StIdle);
  assign DONE      = done_q;
  assign QUOTIENT  = quot_q;
  assign REMAINDER = rem_out_q;
  assign DIV_ZERO  = div_zero_q;
  assign ADD_CIN   = 1'b0;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a vector table of divides plus cancel, busy-start and reset cases.
module tb_div_seq;

  logic        CLK = 1'b0;
  logic        RESETN, START, SIGNED, CANCEL;
  logic [31:0] DIVIDEND, DIVISOR, QUOTIENT, REMAINDER;
  logic        BUSY, DONE, DIV_ZERO, ADD_SUB, ADD_CIN;
  logic [63:0] ADD_A, ADD_B, ADD_SUM;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // Shared adder/subtractor model.
  assign ADD_SUM = ADD_SUB ? (ADD_A - ADD_B) : (ADD_A + ADD_B + {63'b0, ADD_CIN});

  div_seq dut (
    .CLK(CLK), .RESETN(RESETN), .START(START), .SIGNED(SIGNED), .DIVIDEND(DIVIDEND),
    .DIVISOR(DIVISOR), .CANCEL(CANCEL), .BUSY(BUSY), .DONE(DONE), .QUOTIENT(QUOTIENT),
    .REMAINDER(REMAINDER), .DIV_ZERO(DIV_ZERO), .ADD_A(ADD_A), .ADD_B(ADD_B),
    .ADD_SUB(ADD_SUB), .ADD_CIN(ADD_CIN), .ADD_SUM(ADD_SUM)
  );

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one divide and follow it to DONE; optionally poke START (as 5/0) while busy.
  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input int elat, input int poke, input string name);
    int   lat = -1;
    logic busy_ok = 1'b1;
    logic add_ok = 1'b1;
    @(negedge CLK);
    START = 1'b1; SIGNED = sg; DIVIDEND = a; DIVISOR = b;
    @(negedge CLK);
    START = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge CLK);
      START = (k == poke);
      if (k == poke) begin
        SIGNED = ~sg; DIVIDEND = 32'd5; DIVISOR = 32'd0;
      end
      if (ADD_A != 64'd0 || ADD_B != 64'd0 || ADD_SUB) add_ok = 1'b0;
      if (!BUSY) busy_ok = 1'b0;
      if (DONE) begin
        lat = k;
        break;
      end
    end
    START = 1'b0;
    chk({name, "_latency"}, 64'(lat), 64'(elat));
    chk({name, "_q"}, {32'b0, QUOTIENT}, {32'b0, eq});
    chk({name, "_r"}, {32'b0, REMAINDER}, {32'b0, er});
    chk({name, "_dz"}, {63'b0, DIV_ZERO}, {63'b0, edz});
    chk({name, "_busy_during"}, {63'b0, busy_ok}, 64'd1);
    if (edz) chk({name, "_adder_idle"}, {63'b0, add_ok}, 64'd1);
    @(negedge CLK);
    chk({name, "_busy_after"}, {63'b0, BUSY}, 64'd0);
    chk({name, "_done_after"}, {63'b0, DONE}, 64'd0);
  endtask

  initial begin
    logic flag;
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 37};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 37};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 37};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 37};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 37};
    vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};
    vecs[6]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 37};
    vecs[7]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 37};
    vecs[8]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};
    vecs[9]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 37};
    vecs[10] = '{1'b0, 32'h1234_5678,  32'h0000_1000,  32'h0001_2345,  32'h0000_0678,  1'b0, 37};

    RESETN = 1'b1; START = 1'b0; SIGNED = 1'b0; CANCEL = 1'b0;
    DIVIDEND = '0; DIVISOR = '0;
    #2 RESETN = 1'b0;
    #1;
    chk("reset_busy", {63'b0, BUSY}, 64'd0);
    chk("reset_done", {63'b0, DONE}, 64'd0);
    chk("reset_q", {32'b0, QUOTIENT}, 64'd0);
    chk("reset_r", {32'b0, REMAINDER}, 64'd0);
    chk("reset_dz", {63'b0, DIV_ZERO}, 64'd0);
    chk("reset_add", {ADD_A[31:0] | ADD_B[31:0], 31'b0, ADD_SUB}, 64'd0);
    chk("add_cin", {63'b0, ADD_CIN}, 64'd0);
    @(negedge CLK);
    RESETN = 1'b1;

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz,
             vecs[i].lat, 0, $sformatf("vec%0d", i));

    // Cancel in cycle 10 of a 100/7 divide.
    flag = 1'b0;
    @(negedge CLK);
    START = 1'b1; SIGNED = 1'b0; DIVIDEND = 32'd100; DIVISOR = 32'd7;
    @(negedge CLK);
    START = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      @(negedge CLK);
      if (DONE || !BUSY) flag = 1'b1;
    end
    CANCEL = 1'b1;
    @(negedge CLK);
    CANCEL = 1'b0;
    chk("cancel_no_early_done", {63'b0, flag}, 64'd0);
    chk("cancel_busy", {63'b0, BUSY}, 64'd0);
    chk("cancel_done", {63'b0, DONE}, 64'd0);
    chk("cancel_q_held", {32'b0, QUOTIENT}, {32'b0, vecs[NV-1].q});
    chk("cancel_r_held", {32'b0, REMAINDER}, {32'b0, vecs[NV-1].r});
    chk("cancel_dz_held", {63'b0, DIV_ZERO}, {63'b0, vecs[NV-1].dz});

    // CANCEL with START in IDLE: START must be dropped.
    START = 1'b1; CANCEL = 1'b1; DIVIDEND = 32'd9; DIVISOR = 32'd3;
    @(negedge CLK);
    START = 1'b0; CANCEL = 1'b0;
    chk("cancel_start_idle_busy", {63'b0, BUSY}, 64'd0);
    run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 37, 0, "after_cancel");

    // START (5/0) pulsed in cycle 3 while busy must be ignored.
    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 37, 3, "busy_start");

    // Asynchronous reset in cycle 20.
    @(negedge CLK);
    START = 1'b1; SIGNED = 1'b0; DIVIDEND = 32'd9; DIVISOR = 32'd3;
    @(negedge CLK);
    START = 1'b0;
    repeat (19) @(negedge CLK);
    chk("pre_reset_busy", {63'b0, BUSY}, 64'd1);
    RESETN = 1'b0;
    #1;
    chk("mid_reset_busy", {63'b0, BUSY}, 64'd0);
    chk("mid_reset_done", {63'b0, DONE}, 64'd0);
    chk("mid_reset_q", {32'b0, QUOTIENT}, 64'd0);
    chk("mid_reset_r", {32'b0, REMAINDER}, 64'd0);
    chk("mid_reset_add_a", ADD_A, 64'd0);
    chk("mid_reset_add_b", ADD_B, 64'd0);
    chk("mid_reset_add_sub", {63'b0, ADD_SUB}, 64'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 37, 0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
